issue_scoreboard: RTL and testbench

- Issue-stage hazard controller placed directly after instruction decode.
- Tracks general-purpose registers with an outstanding write from long-latency units (loads, multiply/divide).
- Stalls issue on RAW, WAW and capacity hazards.
- Serialises CSR instructions: drains all outstanding writes before a CSR issues, then blocks issue until the CSR completes.

---
 rtl/issue_scoreboard.sv | 147 ++++++++++++++
 tb/tb_issue_scoreboard.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard scoreboard: tracks registers awaiting long-latency writeback,
// stalls issue on RAW/WAW/capacity hazards and serialises CSR instructions.
module issue_scoreboard #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       read_index_1,
  input  logic             read_enable_1,
  input  logic [4:0]       read_index_2,
  input  logic             read_enable_2,
  input  logic [4:0]       write_index,
  input  logic             write_enable,
  input  logic             long_latency,
  input  logic             csr_access,
  input  logic             wb_valid,
  input  logic [4:0]       wb_index,
  input  logic             csr_done,
  output logic             stall,
  output logic             issue_accept,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] outstanding,
  output logic [1:0]       state,
  output logic             wb_error
);

  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    CSR_WAIT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  error_q, error_d;

  logic rs1_hit, rs2_hit, raw, waw, full, drained, rd_nonzero;
  logic do_set, do_clear;

  // Hazard terms use only the registered pending vector (no writeback bypass).
  always_comb begin
    rd_nonzero = (write_index != 5'd0);
    rs1_hit    = read_enable_1 && (read_index_1 != 5'd0) && pending_q[read_index_1];
    rs2_hit    = read_enable_2 && (read_index_2 != 5'd0) && pending_q[read_index_2];
    raw        = rs1_hit || rs2_hit;
    waw        = write_enable && rd_nonzero && pending_q[write_index];
    full       = long_latency && write_enable && rd_nonzero &&
                 (count_q == CNT_W'(MAX_OUTSTANDING));
    drained    = (count_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and combinational issue handshake.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (issue_valid) begin
          if (csr_access) begin
            if (drained && !raw) begin
              state_d = CSR_WAIT;
            end else begin
              stall   = 1'b1;
              state_d = DRAIN;
            end
          end else begin
            stall = raw || waw || full;
          end
        end
      end
      DRAIN: begin
        stall = issue_valid;
        // An upstream flush abandons the pending CSR as well.
        if (drained || !issue_valid) begin
          state_d = RUN;
        end
      end
      CSR_WAIT: begin
        stall = issue_valid;
        if (csr_done) begin
          state_d = RUN;
        end
      end
      default: begin
        stall   = issue_valid;
        state_d = RUN;
      end
    endcase
  end

  assign issue_accept = issue_valid && !stall;

  // Pending-bit set/clear; a set and a clear never target the same register.
  always_comb begin
    do_set   = issue_accept && long_latency && write_enable && rd_nonzero && !csr_access;
    do_clear = wb_valid && pending_q[wb_index];

    pending_d = pending_q;
    if (do_set) begin
      pending_d[write_index] = 1'b1;
    end
    if (do_clear) begin
      pending_d[wb_index] = 1'b0;
    end
    pending_d[0] = 1'b0;

    count_d = count_q;
    unique case ({do_set, do_clear})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    error_d = error_q || (wb_valid && !pending_q[wb_index]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      error_q   <= error_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = count_q;
  assign state       = state_q;
  assign wb_error    = error_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, hand sequences for error/reset,
// then randomized traffic checked against a set-based reference model.
module tb_issue_scoreboard;

  localparam int unsigned MAXO = 4;
  localparam int unsigned CW   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [4:0]    read_index_1, read_index_2, write_index, wb_index;
  logic          read_enable_1, read_enable_2, write_enable;
  logic          long_latency, csr_access, wb_valid, csr_done;
  logic          stall, issue_accept, wb_error;
  logic [31:0]   pending;
  logic [CW-1:0] outstanding;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;

  // Reference model: set of busy registers, abstract mode number, sticky error.
  bit [31:0] m_busy;
  int        m_mode;
  bit        m_err;

  typedef struct {
    logic       iv;
    logic [4:0] r1;
    logic       re1;
    logic [4:0] r2;
    logic       re2;
    logic [4:0] wi;
    logic       we;
    logic       ll;
    logic       csr;
    logic       wbv;
    logic [4:0] wbi;
    logic       cd;
    logic       e_stall;
    logic       e_acc;
    logic [1:0] e_state;
    logic [2:0] e_out;
  } vec_t;

  vec_t tbl[$];

  issue_scoreboard #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .read_index_1(read_index_1), .read_enable_1(read_enable_1),
    .read_index_2(read_index_2), .read_enable_2(read_enable_2),
    .write_index(write_index), .write_enable(write_enable),
    .long_latency(long_latency), .csr_access(csr_access),
    .wb_valid(wb_valid), .wb_index(wb_index), .csr_done(csr_done),
    .stall(stall), .issue_accept(issue_accept), .pending(pending),
    .outstanding(outstanding), .state(state), .wb_error(wb_error)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic iv, logic [4:0] r1, logic re1, logic [4:0] r2, logic re2,
                              logic [4:0] wi, logic we, logic ll, logic csr, logic wbv,
                              logic [4:0] wbi, logic cd, logic es, logic ea,
                              logic [1:0] est, logic [2:0] eo);
    vec_t v;
    v.iv = iv; v.r1 = r1; v.re1 = re1; v.r2 = r2; v.re2 = re2;
    v.wi = wi; v.we = we; v.ll = ll; v.csr = csr; v.wbv = wbv; v.wbi = wbi; v.cd = cd;
    v.e_stall = es; v.e_acc = ea; v.e_state = est; v.e_out = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    issue_valid   = v.iv;
    read_index_1  = v.r1;  read_enable_1 = v.re1;
    read_index_2  = v.r2;  read_enable_2 = v.re2;
    write_index   = v.wi;  write_enable  = v.we;
    long_latency  = v.ll;  csr_access    = v.csr;
    wb_valid      = v.wbv; wb_index      = v.wbi;
    csr_done      = v.cd;
  endtask

  function automatic bit uses_busy(logic en, logic [4:0] idx);
    return en && idx != 5'd0 && m_busy[idx];
  endfunction

  function automatic bit model_stall();
    bit raw, waw, full;
    int cnt;
    if (!issue_valid) return 1'b0;
    cnt  = $countones(m_busy);
    raw  = uses_busy(read_enable_1, read_index_1) || uses_busy(read_enable_2, read_index_2);
    waw  = uses_busy(write_enable, write_index);
    full = long_latency && write_enable && write_index != 5'd0 && cnt == MAXO;
    if (m_mode != 0) return 1'b1;
    if (csr_access)  return !(cnt == 0 && !raw);
    return raw || waw || full;
  endfunction

  // Compare all outputs against the model, then advance the model across one clock.
  task automatic step();
    bit exp_stall, acc;
    int cnt, nmode;
    bit [31:0] nbusy;
    bit nerr;
    exp_stall = model_stall();
    acc       = issue_valid && !exp_stall;
    cnt       = $countones(m_busy);
    chk("m_stall", 32'(stall), 32'(exp_stall));
    chk("m_accept", 32'(issue_accept), 32'(acc));
    chk("m_pending", pending, m_busy);
    chk("m_outstanding", 32'(outstanding), 32'(cnt));
    chk("m_state", 32'(state), 32'(m_mode));
    chk("m_wb_error", 32'(wb_error), 32'(m_err));
    nmode = m_mode;
    case (m_mode)
      0: if (issue_valid && csr_access) nmode = acc ? 2 : 1;
      1: if (cnt == 0 || !issue_valid) nmode = 0;
      default: if (csr_done) nmode = 0;
    endcase
    nbusy = m_busy;
    nerr  = m_err;
    if (acc && long_latency && write_enable && write_index != 5'd0 && !csr_access)
      nbusy[write_index] = 1'b1;
    if (wb_valid) begin
      if (m_busy[wb_index]) nbusy[wb_index] = 1'b0;
      else nerr = 1'b1;
    end
    @(posedge clk);
    m_mode = nmode;
    m_busy = nbusy;
    m_err  = nerr;
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_mode = 0;
    m_err  = 1'b0;
  endtask

  initial begin
    vec_t idle, v;
    idle = mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
    drive(idle);
    model_reset();
    reset = 1'b1;

    // Load x5, dependent add stalls through the writeback cycle.
    tbl.push_back(mk(1,0,0,0,0, 5,1,1,0, 0,0,0, 0,1,0,0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1,5,1,0,0, 10,1,0,0, 0,0,0, 1,0,0,1));
    tbl.push_back(mk(1,5,1,0,0, 10,1,0,0, 1,5,0, 1,0,0,1));
    tbl.push_back(mk(1,5,1,0,0, 10,1,0,0, 0,0,0, 0,1,0,0));
    // Capacity: fill x1..x4, fifth waits for a free slot.
    tbl.push_back(mk(1,0,0,0,0, 1,1,1,0, 0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0, 2,1,1,0, 0,0,0, 0,1,0,1));
    tbl.push_back(mk(1,0,0,0,0, 3,1,1,0, 0,0,0, 0,1,0,2));
    tbl.push_back(mk(1,0,0,0,0, 4,1,1,0, 0,0,0, 0,1,0,3));
    tbl.push_back(mk(1,0,0,0,0, 6,1,1,0, 0,0,0, 1,0,0,4));
    tbl.push_back(mk(1,0,0,0,0, 6,1,1,0, 1,2,0, 1,0,0,4));
    tbl.push_back(mk(1,0,0,0,0, 6,1,1,0, 0,0,0, 0,1,0,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,4,0, 0,0,0,4));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,6,0, 0,0,0,3));
    // WAW on x7; independent add still issues.
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0, 0,0,0, 0,1,0,2));
    tbl.push_back(mk(1,0,0,0,0, 7,1,1,0, 0,0,0, 1,0,0,3));
    tbl.push_back(mk(1,9,1,0,0, 8,1,0,0, 0,0,0, 0,1,0,3));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,7,0, 0,0,0,3));
    // CSR drains x1/x3, issues, then blocks until csr_done.
    tbl.push_back(mk(1,11,1,0,0, 10,1,0,1, 0,0,0, 1,0,0,2));
    tbl.push_back(mk(1,11,1,0,0, 10,1,0,1, 1,1,0, 1,0,1,2));
    tbl.push_back(mk(1,11,1,0,0, 10,1,0,1, 1,3,0, 1,0,1,1));
    tbl.push_back(mk(1,11,1,0,0, 10,1,0,1, 0,0,0, 1,0,1,0));
    tbl.push_back(mk(1,11,1,0,0, 10,1,0,1, 0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,11,1,0,0, 12,1,0,0, 0,0,0, 1,0,2,0));
    tbl.push_back(mk(1,11,1,0,0, 12,1,0,0, 0,0,1, 1,0,2,0));
    tbl.push_back(mk(1,11,1,0,0, 12,1,0,0, 0,0,0, 0,1,0,0));
    // x0 destination, no write, x0 reads.
    tbl.push_back(mk(1,0,0,0,0, 0,1,1,0, 0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0, 5,0,1,0, 0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,1,0,1, 0,0,1,0, 0,0,0, 0,1,0,0));
    // Writeback to a register that is not busy.
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,9,0, 0,0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_pending", pending, 32'd0);
    chk("reset_outstanding", 32'(outstanding), 32'd0);
    chk("reset_wb_error", 32'(wb_error), 32'd0);
    chk("reset_stall_idle", 32'({stall, issue_accept}), 32'd0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_accept", i), 32'(issue_accept), 32'(tbl[i].e_acc));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].e_state));
      chk($sformatf("vec%0d_outstanding", i), 32'(outstanding), 32'(tbl[i].e_out));
      step();
    end

    // Error is sticky and outstanding stays untouched.
    @(negedge clk);
    drive(idle);
    #1;
    chk("err_sticky", 32'(wb_error), 32'd1);
    chk("err_outstanding", 32'(outstanding), 32'd0);
    step();

    // Enter DRAIN, then reset asynchronously mid-cycle.
    @(negedge clk);
    drive(mk(1,0,0,0,0, 1,1,1,0, 0,0,0, 0,0,0,0));
    #1;
    step();
    @(negedge clk);
    drive(mk(1,0,0,0,0, 0,0,0,1, 0,0,0, 0,0,0,0));
    #1;
    step();
    @(negedge clk);
    #1;
    chk("drain_state", 32'(state), 32'd1);
    chk("drain_stall", 32'(stall), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_pending", pending, 32'd0);
    chk("async_rst_outstanding", 32'(outstanding), 32'd0);
    chk("async_rst_wb_error", 32'(wb_error), 32'd0);
    drive(idle);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      v     = idle;
      v.iv  = ($urandom % 4) != 0;
      v.r1  = 5'($urandom % 8);  v.re1 = $urandom % 2;
      v.r2  = 5'($urandom % 8);  v.re2 = $urandom % 2;
      v.wi  = 5'($urandom % 8);  v.we  = ($urandom % 4) != 0;
      v.ll  = ($urandom % 2);
      v.csr = ($urandom % 12) == 0;
      v.wbv = ($urandom % 3) == 0;
      v.wbi = 5'($urandom % 8);
      if (($urandom % 8) != 0) begin
        for (int k = 0; k < 8; k++) begin
          if (m_busy[(int'(v.wbi) + k) % 8]) begin
            v.wbi = 5'((int'(v.wbi) + k) % 8);
            break;
          end
        end
      end
      v.cd = ($urandom % 4) == 0;
      drive(v);
      #1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
